mealy_seq_gen: RTL and testbench

Serial bit-pattern generator that drives a sequence-detector input, one bit per clock. It is the transmit end of the serial bit-stream interface.
- Loads a PATTERN_W-bit pattern and a repetition count on a start request.
- Shifts the pattern out MSB first, repeated N times, with optional idle gaps between repetitions.
- valid_o is Mealy-style: combinational from state and the hold_i input.
- Used as stimulus and source for sequence detectors, e.g. the default 1011 pattern.

---
 rtl/mealy_seq_gen.sv | 104 ++++++++++
 tb/tb_mealy_seq_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_gen.sv
// Serial pattern generator: shifts a latched PATTERN_W-bit word out MSB first,
// repeated a latched number of times, with optional idle gaps between repetitions.
module mealy_seq_gen #(
   parameter int PATTERN_W  = 4,
   parameter int CNT_W      = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [PATTERN_W-1:0] pattern_i,
   input  logic [CNT_W-1:0]     repeat_i,
   input  logic                 hold_i,
   output logic                 bit_o,
   output logic                 valid_o,
   output logic                 last_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int IDX_W = $clog2(PATTERN_W);
   localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PATTERN_W - 1);
   localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [PATTERN_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0]     reps_q, reps_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [GAP_W-1:0]     gap_q, gap_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         reps_q  <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         reps_q  <= reps_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      reps_d  = reps_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (repeat_i != '0) begin
                  pat_d   = pattern_i;
                  reps_d  = repeat_i;
                  idx_d   = IDX_TOP;
                  state_d = S_SEND;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SEND: begin
            if (!hold_i) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - IDX_W'(1);
               end else if (reps_q != CNT_W'(1)) begin
                  // reps_q counts remaining repetitions including the current one
                  reps_d = reps_q - CNT_W'(1);
                  idx_d  = IDX_TOP;
                  if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_TOP;
                  end
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_SEND;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // valid_o and last_o follow hold_i combinationally while sending
   always_comb begin
      bit_o   = (state_q == S_SEND) & pat_q[idx_q];
      valid_o = (state_q == S_SEND) & ~hold_i;
      last_o  = (state_q == S_SEND) & ~hold_i & (idx_q == '0);
      busy_o  = (state_q == S_SEND) | (state_q == S_GAP);
      done_o  = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_mealy_seq_gen.sv
// Directed bench for mealy_seq_gen: per-cycle expected outputs are queued as
// stimulus is planned and checked each cycle against two instances (gap 0 and gap 2).
module tb_mealy_seq_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_v, hold_v, sel;
   logic [3:0] pattern_v;
   logic [7:0] repeat_v;
   logic       b0, v0, l0, bu0, d0;
   logic       b1, v1, l1, bu1, d1;
   logic       ob, ov, ol, obu, od;
   int         total = 0;
   int         bad   = 0;

   typedef struct packed {
      logic start, hold, b, v, l, busy, done;
   } item_t;
   item_t sb[$];
   item_t it;

   always #5 clk = ~clk;

   mealy_seq_gen #(.PATTERN_W(4), .CNT_W(8), .GAP_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start_v & ~sel), .pattern_i(pattern_v),
      .repeat_i(repeat_v), .hold_i(hold_v),
      .bit_o(b0), .valid_o(v0), .last_o(l0), .busy_o(bu0), .done_o(d0));

   mealy_seq_gen #(.PATTERN_W(4), .CNT_W(8), .GAP_CYCLES(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start_v & sel), .pattern_i(pattern_v),
      .repeat_i(repeat_v), .hold_i(hold_v),
      .bit_o(b1), .valid_o(v1), .last_o(l1), .busy_o(bu1), .done_o(d1));

   assign ob  = sel ? b1  : b0;
   assign ov  = sel ? v1  : v0;
   assign ol  = sel ? l1  : l0;
   assign obu = sel ? bu1 : bu0;
   assign od  = sel ? d1  : d0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input item_t e);
      chk({tag, ".bit"},   ob,  e.b);
      chk({tag, ".valid"}, ov,  e.v);
      chk({tag, ".last"},  ol,  e.l);
      chk({tag, ".busy"},  obu, e.busy);
      chk({tag, ".done"},  od,  e.done);
   endtask

   task automatic push(input logic s, h, b, v, l, bu, d);
      item_t e;
      e = '{start: s, hold: h, b: b, v: v, l: l, busy: bu, done: d};
      sb.push_back(e);
   endtask

   // Reference stream: reps copies of pat MSB first, gap idle cycles between, then done, then idle
   task automatic expect_run(input logic [3:0] pat, input int reps, input int gap);
      for (int r = 0; r < reps; r++) begin
         if (r > 0)
            for (int g = 0; g < gap; g++) push(0, 0, 0, 0, 0, 1, 0);
         for (int i = 3; i >= 0; i--) push(0, 0, pat[i], 1, (i == 0), 1, 0);
      end
      push(0, 0, 0, 0, 0, 0, 1);
      push(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic launch(input logic which, input logic [3:0] pat, input logic [7:0] rep);
      @(negedge clk);
      sel       = which;
      pattern_v = pat;
      repeat_v  = rep;
      start_v   = 1'b1;
      @(negedge clk);
      start_v   = 1'b0;
      pattern_v = ~pat;
      repeat_v  = 8'd5;
   endtask

   task automatic drain(input string tag);
      while (sb.size() > 0) begin
         it      = sb.pop_front();
         start_v = it.start;
         hold_v  = it.hold;
         #1;
         chk_all(tag, it);
         @(negedge clk);
      end
      start_v = 1'b0;
      hold_v  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start_v = 1'b0; hold_v = 1'b0; sel = 1'b0;
      pattern_v = 4'b0; repeat_v = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all("reset0", '0);
      sel = 1'b1; #1;
      chk_all("reset1", '0);

      // single repetition of 1011
      launch(1'b0, 4'b1011, 8'd1);
      expect_run(4'b1011, 1, 0);
      drain("single");

      // three back-to-back reps with a stray start pulse mid-stream
      launch(1'b0, 4'b1011, 8'd3);
      expect_run(4'b1011, 3, 0);
      it = sb[5]; it.start = 1'b1; sb[5] = it;
      drain("rep3");

      // two reps separated by a two-cycle gap
      launch(1'b1, 4'b1011, 8'd2);
      expect_run(4'b1011, 2, 2);
      drain("gap2");

      // hold for three cycles on the second bit
      launch(1'b0, 4'b1011, 8'd1);
      push(0, 0, 1, 1, 0, 1, 0);
      push(0, 1, 0, 0, 0, 1, 0);
      push(0, 1, 0, 0, 0, 1, 0);
      push(0, 1, 0, 0, 0, 1, 0);
      push(0, 0, 0, 1, 0, 1, 0);
      push(0, 0, 1, 1, 0, 1, 0);
      push(0, 0, 1, 1, 1, 1, 0);
      push(0, 0, 0, 0, 0, 0, 1);
      push(0, 0, 0, 0, 0, 0, 0);
      drain("hold");

      // zero repetitions: immediate done, never busy
      launch(1'b0, 4'b1011, 8'd0);
      expect_run(4'b1011, 0, 0);
      drain("rep0");

      // reset during the third bit aborts with no done pulse
      launch(1'b0, 4'b1011, 8'd1);
      push(0, 0, 1, 1, 0, 1, 0);
      push(0, 0, 0, 1, 0, 1, 0);
      drain("abort_pre");
      #1;
      chk_all("abort_bit3", '{start: 0, hold: 0, b: 1, v: 1, l: 0, busy: 1, done: 0});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) push(0, 0, 0, 0, 0, 0, 0);
      drain("abort_post");

      // fresh transfer after the abort
      launch(1'b0, 4'b0110, 8'd1);
      expect_run(4'b0110, 1, 0);
      drain("fresh");

      // maximum repetition count must not wrap
      launch(1'b0, 4'b1011, 8'd255);
      expect_run(4'b1011, 255, 0);
      drain("rep255");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
